// File: rtl/new_cache_types.sv
// Shared types and sizing for the cache line / memory burst datapath.
package new_cache_types;

    localparam int unsigned s_line     = 256;
    localparam int unsigned s_burst    = 64;
    localparam int unsigned num_bursts = s_line / s_burst;
    localparam int unsigned cnt_w      = $clog2(num_bursts);
    localparam int unsigned addr_w     = 32;
    localparam int unsigned off_w      = $clog2(s_line / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adapter_state_t;

endpackage

// File: rtl/new_cacheline_adapter.sv
// Converts one 256-bit cache line request into a 4-beat 64-bit memory burst.
module new_cacheline_adapter
    import new_cache_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [addr_w-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [addr_w-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    adapter_state_t                      state;
    logic [cnt_w-1:0]                    cnt;
    logic [cnt_w-1:0]                    cnt_nxt;
    logic                                last_beat;
    logic [num_bursts-1:0][s_burst-1:0]  line_buf;
    logic                                unused_offset;

    assign cnt_nxt       = cnt + cnt_w'(1);
    assign last_beat     = (cnt == cnt_w'(num_bursts - 1));
    assign line_o        = line_buf;
    assign unused_offset = ^address_i[off_w-1:0];

    // Memory-side outputs are registered alongside the state so they change
    // in the same cycle the state does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            address_o <= '0;
            burst_o   <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    if (write_i) begin
                        line_buf  <= line_i;
                        address_o <= {address_i[addr_w-1:off_w], off_w'(0)};
                        cnt       <= '0;
                        burst_o   <= line_i[s_burst-1:0];
                        write_o   <= 1'b1;
                        state     <= WR_BURST;
                    end else if (read_i) begin
                        address_o <= {address_i[addr_w-1:off_w], off_w'(0)};
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_buf[cnt] <= burst_i;
                        cnt           <= cnt_nxt;
                        if (last_beat) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= RD_DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt     <= cnt_nxt;
                        burst_o <= line_buf[cnt_nxt];
                        if (last_beat) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= WR_DONE;
                        end
                    end
                end
                RD_DONE, WR_DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    resp_o  <= 1'b0;
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_new_cacheline_adapter.sv
// Directed self-checking bench for new_cacheline_adapter.
module tb_new_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int passed = 0;
    int total  = 0;

    new_cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".resp_o"},    256'(resp_o),    256'(0));
        chk({tag, ".read_o"},    256'(read_o),    256'(0));
        chk({tag, ".write_o"},   256'(write_o),   256'(0));
        chk({tag, ".burst_o"},   256'(burst_o),   256'(0));
        chk({tag, ".address_o"}, 256'(address_o), 256'(0));
        chk({tag, ".line_o"},    line_o,          256'(0));
    endtask

    logic [63:0]  beats [4];
    logic [255:0] wline;
    int           beat;
    int           resp_seen;

    initial begin
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
        burst_i = '0; resp_i = 0;
        #12;
        chk_all_zero("reset");
        step();
        rst = 1'b1;
        step();

        // Zero-wait read; this step is cycle 0.
        address_i = 32'h0000_1234; read_i = 1;
        beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}}; beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("zw_rd.read_o", 256'(read_o), 256'(1));
            chk("zw_rd.resp_o_early", 256'(resp_o), 256'(0));
            chk("zw_rd.address_o", 256'(address_o), 256'(32'h0000_1220));
            resp_i = 1; burst_i = beats[c-1];
        end
        step();
        chk("zw_rd.resp_o", 256'(resp_o), 256'(1));
        chk("zw_rd.read_o_done", 256'(read_o), 256'(0));
        chk("zw_rd.line_o", line_o, {beats[3], beats[2], beats[1], beats[0]});
        read_i = 0; resp_i = 0;
        step();
        chk("zw_rd.resp_o_one_cycle", 256'(resp_o), 256'(0));

        // Waited write: resp_i only on even cycles 2,4,6,8.
        wline = {64'd3, 64'd2, 64'd1, 64'd0};
        line_i = wline; address_i = 32'h0000_ABCD; write_i = 1;
        beat = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            write_i = 0;
            chk("wait_wr.write_o", 256'(write_o), 256'(1));
            chk("wait_wr.burst_o", 256'(burst_o), 256'(beat));
            chk("wait_wr.resp_o_early", 256'(resp_o), 256'(0));
            resp_i = (c % 2 == 0);
            if (resp_i) beat++;
        end
        step();
        resp_i = 0;
        chk("wait_wr.resp_o_c9", 256'(resp_o), 256'(1));
        chk("wait_wr.write_o_done", 256'(write_o), 256'(0));
        chk("wait_wr.address_o", 256'(address_o), 256'(32'h0000_ABC0));
        step();

        // Simultaneous read and write requests: write wins.
        line_i = {4{64'hDEAD_BEEF_0000_0001}}; address_i = 32'h0000_0100;
        read_i = 1; write_i = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("both.write_o", 256'(write_o), 256'(1));
            chk("both.read_o", 256'(read_o), 256'(0));
            resp_i = 1;
        end
        step();
        read_i = 0; write_i = 0; resp_i = 0;
        chk("both.resp_o", 256'(resp_o), 256'(1));
        chk("both.read_o_done", 256'(read_o), 256'(0));
        step();

        // Back-to-back: write then read requested in the cycle after resp_o.
        line_i = {64'hA3, 64'hA2, 64'hA1, 64'hA0}; address_i = 32'h1000_0047; write_i = 1;
        step();
        write_i = 0;
        chk("b2b.wr_address_o", 256'(address_o), 256'(32'h1000_0040));
        chk("b2b.wr_burst0", 256'(burst_o), 256'(64'hA0));
        resp_i = 1;
        for (int c = 2; c <= 4; c++) step();
        step();
        resp_i = 0;
        chk("b2b.wr_resp_o", 256'(resp_o), 256'(1));
        step();
        chk("b2b.idle_read_o", 256'(read_o), 256'(0));
        address_i = 32'h2000_00FF; read_i = 1;
        step();
        read_i = 0;
        chk("b2b.rd_read_o", 256'(read_o), 256'(1));
        chk("b2b.rd_address_o", 256'(address_o), 256'(32'h2000_00E0));
        resp_i = 1; burst_i = 64'h5555_0000;
        for (int c = 2; c <= 4; c++) begin step(); burst_i = burst_i + 64'd1; end
        step();
        resp_i = 0;
        chk("b2b.rd_resp_o", 256'(resp_o), 256'(1));
        chk("b2b.rd_line_o", line_o, {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000});
        step();

        // Reset mid-read after two beats.
        address_i = 32'h0000_3000; read_i = 1;
        step();
        read_i = 0; resp_i = 1; burst_i = 64'h9999;
        step();
        burst_i = 64'h8888;
        step();
        resp_i = 0;
        chk("rst_mid.read_o_before", 256'(read_o), 256'(1));
        #1 rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst = 1'b1;
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (resp_o) resp_seen++;
        end
        chk("rst_mid.no_resp", 256'(resp_seen), 256'(0));
        address_i = 32'h0000_4010; read_i = 1;
        step();
        read_i = 0; resp_i = 1;
        chk("rst_mid.new_address_o", 256'(address_o), 256'(32'h0000_4000));
        for (int c = 0; c < 4; c++) begin burst_i = 64'hF0 + 64'(c); step(); end
        resp_i = 0;
        chk("rst_mid.new_resp_o", 256'(resp_o), 256'(1));
        chk("rst_mid.new_line_o", line_o, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
        step();

        // Spurious resp_i in IDLE must not advance anything.
        resp_i = 1; burst_i = 64'hBAD0_BAD0;
        step();
        step();
        chk("spur.read_o", 256'(read_o), 256'(0));
        chk("spur.resp_o", 256'(resp_o), 256'(0));
        resp_i = 0;
        address_i = 32'h0000_5000; read_i = 1;
        step();
        read_i = 0; resp_i = 1;
        for (int c = 0; c < 4; c++) begin burst_i = 64'hC0 + 64'(c); step(); end
        resp_i = 0;
        chk("spur.resp_o_after", 256'(resp_o), 256'(1));
        chk("spur.line_o_slice0_first", line_o, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/new_cacheline_adapter.md
# new_cacheline_adapter

Memory-side responder for the cache datapath's line interface. It accepts one 256-bit line read or write request from the cache, runs it as a 4-beat, 64-bit burst transaction with physical memory, and signals completion back to the cache with a one-cycle response. It sits between the cache (its `pmem_*` ports) and the physical memory burst port.

## Interface
Parameters:
- `s_line`, 256, cache line width in bits.
- `s_burst`, 64, memory beat width in bits.
- `num_bursts`, `s_line/s_burst` (4), beats per line.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `line_i`  in  s_line  write line from the cache.
- `line_o`  out  s_line  read line to the cache.
- `address_i`  in  32  line address from the cache.
- `read_i`  in  1  cache line-read request.
- `write_i`  in  1  cache line-write request.
- `resp_o`  out  1  one-cycle completion pulse to the cache.
- `burst_i`  in  s_burst  read beat from memory.
- `burst_o`  out  s_burst  write beat to memory.
- `address_o`  out  32  burst base address to memory.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat acknowledge.

## Operation
- The FSM states are IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- The block holds a 2-bit beat counter `cnt` and a `s_line` line buffer.
- **IDLE:**
  - If `write_i` is high, latch `line_i` into the buffer and `{address_i[31:5], 5'b0}` into the address register, clear `cnt`, and go to WR_BURST.
  - Else, if `read_i` is high, latch the address, clear `cnt`, and go to RD_BURST.
  - Write has priority when both requests are high.
  - `resp_i` is ignored in IDLE.
- **RD_BURST:**
  - `read_o` is 1.
  - Each cycle with `resp_i` high, write `burst_i` into buffer slice `[cnt*64 +: 64]` and increment `cnt`.
  - On the beat where `cnt == 3`, go to RD_DONE.
  - Cycles with `resp_i` low hold all state; gaps between beats are legal.
- **RD_DONE:** `resp_o` is 1 for exactly one cycle, `line_o` shows the filled buffer, then go to IDLE.
- **WR_BURST:**
  - `write_o` is 1 and `burst_o` is buffer slice `[cnt*64 +: 64]`.
  - Each `resp_i` increments `cnt`.
  - On the beat where `cnt == 3`, go to WR_DONE.
- **WR_DONE:** `resp_o` is 1 for one cycle, then go to IDLE.
- `read_i`, `write_i`, `address_i` and `line_i` are sampled only in IDLE. Changes during a burst have no effect.
- `address_o` is the latched address at all times, with the low 5 bits always 0. It does not increment per beat; memory sequences the beats.
- `line_o` always reflects the buffer. It is guaranteed correct only while `resp_o` is 1.
- A request held high through RD_DONE/WR_DONE and still high in the following IDLE cycle starts a new transaction. The cache is responsible for dropping the request after `resp_o`.

## Timing
- All outputs are decoded from registered state and registers; there is no combinational path from `read_i`/`write_i` to memory outputs.
- Request high in IDLE at cycle 0 gives `read_o`/`write_o` high from cycle 1.
- With zero-wait memory (`resp_i` high in cycles 1–4), the request drops in cycle 5 and `resp_o` is 1 in cycle 5. Minimum request-to-response latency is 5 cycles; each memory wait cycle adds 1.
- `read_o`/`write_o` stay high continuously from the first beat through the cycle of the 4th `resp_i`, and are low in the DONE cycle.
- On reset (asynchronous, any state including mid-burst):
  - the state returns to IDLE and `cnt` clears to 0;
  - the buffer and address register clear to 0;
  - `resp_o`, `read_o` and `write_o` are 0, and `burst_o`, `address_o` and `line_o` are all-zero.
- A partial burst is abandoned without a response.
- `cnt` wraps from 3 to 0 on the final beat.

## Structure
- Shared package `new_cache_types`:
  - `s_line`, `s_burst`, `num_bursts` constants;
  - `adapter_state_t` enum (IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE).
- Single module with no sub-module. The line buffer is a plain register array indexed by `cnt`.

## Test plan
- **Zero-wait read:** `address_i=0x0000_1234`, `read_i` high; memory returns beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` in cycles 1–4.
  - `address_o=0x0000_1220`.
  - `resp_o` is high in cycle 5 only.
  - `line_o={0x44..44,0x33..33,0x22..22,0x11..11}`.
- **Waited write:** `line_i` with word `k` = `k`, `write_i` high, `resp_i` high only every other cycle.
  - `burst_o` steps through slices 0–3, and only on `resp_i` cycles.
  - `write_o` is continuously high.
  - `resp_o` is high one cycle after the 4th beat, at cycle 9.
- **Simultaneous `read_i` and `write_i` in IDLE:** `write_o` asserts and `read_o` stays 0 throughout.
- **Back-to-back:** a write, then `read_i` high in the cycle after `resp_o`.
  - The read starts without an idle gap beyond the DONE cycle.
  - The addresses of both transactions are correct.
- **Reset mid-read after 2 beats:**
  - All outputs go to 0 immediately (asynchronously).
  - There is no `resp_o`.
  - A subsequent read completes normally with fresh data.
- **Spurious `resp_i` in IDLE:** `resp_i` pulsed with no request.
  - No state change.
  - `cnt` stays 0.
  - The next read fills slice 0 first.
